// File: rtl/rs_correct_single.sv
// rs_correct_single: single-symbol error corrector for RS(18,16) over GF(2^8) (poly 0x11D)
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready high only while idle
//   v, s1, s2           : received word (symbol j at [8j+7:8j]) and its two syndromes
//   out_valid/out_ready : output handshake; outputs held stable while out_ready is low
//   c                   : corrected word (v unmodified on failure)
//   err_found/err_fixed/err_fail/err_loc : status flags and corrected symbol index
module rs_correct_single #(
    parameter int N            = 18,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*SYMBOL_WIDTH-1:0] v,
    input  logic [SYMBOL_WIDTH-1:0]   s1,
    input  logic [SYMBOL_WIDTH-1:0]   s2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*SYMBOL_WIDTH-1:0] c,
    output logic                      err_found,
    output logic                      err_fixed,
    output logic                      err_fail,
    output logic [4:0]                err_loc
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                      r_state, w_next;
    logic [N*SYMBOL_WIDTH-1:0]   r_c;
    logic [SYMBOL_WIDTH-1:0]     r_s2, r_acc, r_e, w_acc_alpha;
    logic [4:0]                  r_j, r_loc;
    logic                        r_out_valid, r_found, r_fixed, r_fail;
    logic                        w_accept, w_hit, w_last;

    assign w_accept    = in_valid && r_state == IDLE;
    assign w_hit       = r_acc == r_s2;
    assign w_last      = r_j == 5'(N - 1);
    // acc * alpha modulo x^8+x^4+x^3+x^2+1
    assign w_acc_alpha = {r_acc[6:0], 1'b0} ^ (r_acc[7] ? 8'h1D : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !in_valid ? IDLE : (s1 != '0 && s2 != '0) ? SEARCH : DONE;
            SEARCH:  w_next = (w_hit || w_last) ? DONE : SEARCH;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = r_state == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_s2        <= '0;
            r_acc       <= '0;
            r_e         <= '0;
            r_j         <= '0;
            r_loc       <= '0;
            r_found     <= 1'b0;
            r_fixed     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_out_valid <= w_next == DONE;
            if (w_accept) begin
                r_c     <= v;
                r_s2    <= s2;
                r_acc   <= s1;
                r_e     <= s1;
                r_j     <= '0;
                r_found <= s1 != '0 || s2 != '0;
                // exactly one syndrome zero cannot be a single-symbol error
                r_fail  <= (s1 == '0) != (s2 == '0);
                r_fixed <= 1'b0;
                r_loc   <= '0;
            end else if (r_state == SEARCH) begin
                if (w_hit) begin
                    r_c[{r_j, 3'b000} +: SYMBOL_WIDTH] <= r_c[{r_j, 3'b000} +: SYMBOL_WIDTH] ^ r_e;
                    r_fixed <= 1'b1;
                    r_loc   <= r_j;
                end else if (w_last) begin
                    r_fail <= 1'b1;
                end else begin
                    r_acc <= w_acc_alpha;
                    r_j   <= r_j + 5'd1;
                end
            end else if (r_state == DONE && out_ready) begin
                r_found <= 1'b0;
                r_fixed <= 1'b0;
                r_fail  <= 1'b0;
                r_loc   <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign err_found = r_found;
    assign err_fixed = r_fixed;
    assign err_fail  = r_fail;
    assign err_loc   = r_loc;
endmodule

// File: doc/rs_correct_single.md
# rs_correct_single

Sequential single-symbol error corrector for the RS(18,16) GF(2^8) decoder. It sits directly downstream of the syndrome stage and takes the received 18-symbol word with its two syndromes s1 and s2. It locates a single erroneous symbol by iterative α-stepping search, corrects it, and flags words with no error, a corrected error, or an uncorrectable pattern. It has a valid/ready handshake on both sides and processes one word at a time.

## Interface
- N, 18, codeword length in symbols
- SYMBOL_WIDTH, 8, bits per symbol
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  word and syndromes present
- in_ready  out  1  block can accept (high only in IDLE)
- v  in  N*SYMBOL_WIDTH  received word; symbol j at bits [8j+7:8j]
- s1  in  SYMBOL_WIDTH  syndrome: XOR of all symbols
- s2  in  SYMBOL_WIDTH  syndrome: XOR over j of v_j·α^j
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c  out  N*SYMBOL_WIDTH  corrected word (same symbol layout as v)
- err_found  out  1  a nonzero syndrome was seen
- err_fixed  out  1  one symbol was corrected
- err_fail  out  1  uncorrectable; c equals v unmodified
- err_loc  out  5  corrected symbol index (0..17); 0 when err_fixed=0

## Operation
- GF(2^8) uses primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). The multiply-by-α operation is a = (a<<1) ^ (a[7] ? 0x1D : 0), truncated to 8 bits.
- The FSM has three states: IDLE, SEARCH and DONE.
- IDLE: in_ready=1. On the in_valid&in_ready edge, register v into c. Also register s2, set acc=s1 (error magnitude register e=s1) and set j=0. Then:
  - s1=0 and s2=0: go to DONE with no flags set.
  - Exactly one of s1, s2 is zero: go to DONE with err_found=1 and err_fail=1.
  - Both nonzero: go to SEARCH with err_found=1.
- SEARCH evaluates one candidate per cycle, in priority order at each edge:
  - acc==s2: c symbol j ^= e, err_fixed=1, err_loc=j, go to DONE.
  - Otherwise, if j==17: err_fail=1, c unchanged, go to DONE.
  - Otherwise: acc = acc·α, j = j+1.
- DONE: out_valid=1, and c and the flags are held stable. On the out_valid&out_ready edge, go to IDLE and clear the flags and err_loc. c may keep its stale value.
- Only one word is in flight at a time. in_ready=0 in SEARCH and DONE, and in_valid is ignored there.
- err_fixed and err_fail are mutually exclusive. err_fixed or err_fail implies err_found.
- The 5-bit j counter never exceeds 17.

## Timing
- Reset (asynchronous assert, synchronous release by clk) sets:
  - state=IDLE, so in_ready=1;
  - out_valid=0, c=0, err_found=0, err_fixed=0, err_fail=0, err_loc=0, acc=0, j=0.
- Reset asserted mid-SEARCH or mid-DONE aborts the word immediately. No output is produced for it.
- Latency, measured from the acceptance edge E0 to the first cycle with out_valid high:
  - Clean word or syndrome-zero mismatch: out_valid is high after E0 (DONE entered at E0).
  - Error at symbol j: DONE is entered at edge E0+j+1.
  - Uncorrectable after search: DONE is entered at edge E0+18.
- in_ready returns high in the cycle after the output handshake edge. The minimum throughput period is therefore 2 cycles per clean word.
- out_ready held low stalls the block in DONE indefinitely, with outputs stable.
- in_ready is a combinational decode of state. out_valid and all data and flags are registered.

## Test plan
- Clean word: v=all 0x00, s1=0, s2=0 → out_valid high after E0; c=v; all flags 0; in_ready high one cycle after out_ready handshake.
- Error at symbol 0: symbol 0 = 0x5A, rest 0, s1=0x5A, s2=0x5A → DONE at E0+1; c all zero; err_fixed=1, err_loc=0.
- Error at symbol 17: symbol 17 = 0x01, s1=0x01, s2=0x98 (α^17) → DONE at E0+18; c all zero; err_fixed=1, err_loc=17. Also run symbol 3 = 0x01 with s2=0x08 → DONE at E0+4, err_loc=3.
- Uncorrectable cases:
  - s1=0x01, s2=0x03 → search exhausts, DONE at E0+18, err_fail=1, c=v.
  - s1=0x00, s2=0x10 → DONE at E0, err_fail=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → c and flags unchanged, in_ready=0, in_valid ignored. Release → IDLE next cycle.
- Reset during SEARCH (rst_n low at E0+5 of the symbol-17 case) → out_valid never asserts; after release in_ready=1 and all outputs are 0.
